// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   ifu_state_t : fetch controller state (FETCH, HOLD, DRAIN)
//   addr_t      : 64-bit architectural address
//   RESET_PC    : first fetch address after reset
//   NOP_INSTR   : instruction word presented while nothing has been fetched
package ifu_fetch_pkg;

   typedef logic [63:0] addr_t;

   localparam addr_t       RESET_PC  = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN
   } ifu_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch
// Instruction fetch stage sitting directly upstream of the decoder. Owns the
// architectural PC, keeps at most one request outstanding to instruction
// memory, buffers one returned instruction and hands it to the decoder with a
// valid/ready handshake. Redirects from downstream replace the PC and any
// fetch already in flight is discarded.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_req        : fetch request valid (high in FETCH and DRAIN)
//   imem_addr       : fetch address, always the internal fetch PC
//   imem_ack        : memory response valid, only meaningful while imem_req
//   imem_rdata      : returned instruction word
//   redirect_valid  : downstream PC change request
//   redirect_pc     : redirect target, low two bits ignored
//   instr_valid     : buffered instruction available
//   instr, instr_pc : buffered instruction and its PC
//   id_ready        : decoder accepts instr when instr_valid & id_ready
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = ifu_fetch_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            id_ready
);

   ifu_state_t      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pend_pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;

   // Instructions are word aligned; misaligned targets are silently truncated.
   assign target    = {redirect_pc[XLEN-1:2], 2'b00};

   // Only HOLD stops requesting, so the address stays put while a request is
   // outstanding because pc only moves on an ack or from a non-requesting state.
   assign imem_req  = (state != HOLD);
   assign imem_addr = pc;

   // Next fetch address. A redirect that races an ack always wins over the
   // sequential pc+4, and in DRAIN the ack closes the stale request so the
   // saved (or even newer) target can finally go out.
   always_comb begin
      next_pc = pc;
      case (state)
         FETCH: begin
            if (imem_ack) begin
               next_pc = redirect_valid ? target : pc + XLEN'(4);
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               next_pc = target;
            end
         end
         DRAIN: begin
            if (imem_ack) begin
               next_pc = redirect_valid ? target : pend_pc;
            end
         end
         default: next_pc = pc;
      endcase
   end

   // Controller and output registers. In HOLD a redirect and a consume both
   // just empty the buffer; the redirecting instruction is older, so dropping
   // the buffered one is correct either way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         pend_pc     <= '0;
         instr_valid <= 1'b0;
         instr       <= NOP_INSTR;
         instr_pc    <= '0;
      end else begin
         pc <= next_pc;
         case (state)
            FETCH: begin
               if (imem_ack && !redirect_valid) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end else if (!imem_ack && redirect_valid) begin
                  // Request cannot be withdrawn; remember where to go once
                  // its response has been swallowed.
                  pend_pc <= target;
                  state   <= DRAIN;
               end
            end
            HOLD: begin
               if (redirect_valid || id_ready) begin
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  state <= FETCH;
               end else if (redirect_valid) begin
                  pend_pc <= target;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
